// File: rtl/axil_pkg.sv
// axil_pkg: shared AXI4-Lite response codes and default sizing for the register slave.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_e;

    localparam int          AXIL_ADDR_WIDTH = 32;
    localparam int          AXIL_DATA_WIDTH = 32;
    localparam int          AXIL_NUM_REGS   = 16;
    localparam logic [31:0] AXIL_ID_VALUE   = 32'hA11E_0001;

endpackage

// File: rtl/axil_slot.sv
// axil_slot: one-entry holding register; fills on handshake, empties on clear.
module axil_slot #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    input  logic         clr_i,
    output logic         ready_o,
    output logic         full_o,
    output logic [W-1:0] data_o
);
    logic         full_q, full_d, fill;
    logic [W-1:0] data_q, data_d;

    assign ready_o = rst_n & ~full_q;
    assign fill    = valid_i & ready_o;
    assign full_o  = full_q;
    assign data_o  = data_q;

    always_comb begin
        full_d = fill | (full_q & ~clr_i);
        data_d = fill ? data_i : data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            data_q <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
        end
    end
endmodule

// File: rtl/axil_slave_regs.sv
// axil_slave_regs: AXI4-Lite register bank; AW/W joined into one commit, registered reads,
// register 0 is a read-only ID and out-of-range indices answer SLVERR.
module axil_slave_regs
    import axil_pkg::*;
#(
    parameter int          ADDR_WIDTH = AXIL_ADDR_WIDTH,
    parameter int          DATA_WIDTH = AXIL_DATA_WIDTH,
    parameter int          NUM_REGS   = AXIL_NUM_REGS,
    parameter logic [31:0] ID_VALUE   = AXIL_ID_VALUE
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   awaddr,
    input  logic                    awvalid,
    output logic                    awready,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic                    wvalid,
    output logic                    wready,
    output logic [1:0]              bresp,
    output logic                    bvalid,
    input  logic                    bready,
    input  logic [ADDR_WIDTH-1:0]   araddr,
    input  logic                    arvalid,
    output logic                    arready,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic [1:0]              rresp,
    output logic                    rvalid,
    input  logic                    rready
);
    localparam int SW   = DATA_WIDTH / 8;
    localparam int OFFW = $clog2(SW);
    localparam int IDXW = $clog2(NUM_REGS);

    logic                   aw_full, w_full, commit, ar_hs, aw_err, ar_err;
    logic [ADDR_WIDTH-1:0]  aw_addr;
    logic [SW+DATA_WIDTH-1:0] w_pay;
    logic [SW-1:0]          w_strb;
    logic [DATA_WIDTH-1:0]  w_data;
    logic [IDXW-1:0]        aw_idx, ar_idx;
    logic                   bvalid_q, bvalid_d, rvalid_q, rvalid_d;
    axil_resp_e             bresp_q, bresp_d, rresp_q, rresp_d, aw_resp;
    logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic [DATA_WIDTH-1:0]  regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]  regs_d [NUM_REGS];
    logic                   unused_ok;

    axil_slot #(.W(ADDR_WIDTH)) u_aw_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (awvalid),
        .data_i  (awaddr),
        .clr_i   (commit),
        .ready_o (awready),
        .full_o  (aw_full),
        .data_o  (aw_addr)
    );

    axil_slot #(.W(SW + DATA_WIDTH)) u_w_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (wvalid),
        .data_i  ({wstrb, wdata}),
        .clr_i   (commit),
        .ready_o (wready),
        .full_o  (w_full),
        .data_o  (w_pay)
    );

    assign {w_strb, w_data} = w_pay;
    // Byte-offset bits carry no meaning for whole-word registers.
    assign unused_ok = ^{aw_addr[OFFW-1:0], araddr[OFFW-1:0]};

    assign aw_idx  = aw_addr[OFFW +: IDXW];
    assign aw_err  = |(aw_addr >> (OFFW + IDXW));
    assign ar_idx  = araddr[OFFW +: IDXW];
    assign ar_err  = |(araddr >> (OFFW + IDXW));
    assign aw_resp = (aw_err || aw_idx == '0) ? SLVERR : OKAY;

    assign commit  = aw_full & w_full & (~bvalid_q | bready);
    assign arready = rst_n & ~rvalid_q;
    assign ar_hs   = arvalid & arready;

    always_comb begin
        regs_d = regs_q;
        for (int b = 0; b < SW; b++)
            if (commit && aw_resp == OKAY && w_strb[b])
                regs_d[aw_idx][8*b +: 8] = w_data[8*b +: 8];
    end

    // Reads sample regs_q, so a same-edge commit to the same register is not visible yet.
    always_comb begin
        bvalid_d = commit | (bvalid_q & ~bready);
        bresp_d  = commit ? aw_resp : bresp_q;
        rvalid_d = ar_hs | (rvalid_q & ~rready);
        rresp_d  = ar_hs ? (ar_err ? SLVERR : OKAY) : rresp_q;
        rdata_d  = !ar_hs ? rdata_q :
                   ar_err ? '0 :
                   (ar_idx == '0) ? DATA_WIDTH'(ID_VALUE) : regs_q[ar_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid_q <= 1'b0;
            bresp_q  <= OKAY;
            rvalid_q <= 1'b0;
            rresp_q  <= OKAY;
            rdata_q  <= '0;
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            bvalid_q <= bvalid_d;
            bresp_q  <= bresp_d;
            rvalid_q <= rvalid_d;
            rresp_q  <= rresp_d;
            rdata_q  <= rdata_d;
            regs_q   <= regs_d;
        end
    end

    assign bvalid = bvalid_q;
    assign bresp  = bresp_q;
    assign rvalid = rvalid_q;
    assign rresp  = rresp_q;
    assign rdata  = rdata_q;
endmodule
